// File: rtl/code_conv_sched.sv
// code_conv_sched
//   Round-robin scheduler that shares one binary/Gray code converter among
//   N requesters. Binary->Gray finishes in a single conversion cycle.
//   Gray->binary is resolved bit-serially from MSB to LSB, one bit per cycle.
//   The result is returned over a valid/ready handshake and tagged with the
//   id of the requester that owns it.
//
// Optional feature macro: CC_PARITY_EN
//   When it is defined, the block adds out_parity, the XOR-reduce of
//   out_data. It is registered with out_data.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   req        : per-requester request, held until its grant bit is seen
//   req_mode   : per-requester direction (0 = bin->Gray, 1 = Gray->bin)
//   req_data   : per-requester word, slice i = [i*W +: W]
//   grant      : one-hot pulse in the first conversion cycle
//   out_valid  : result available (high throughout DONE)
//   out_ready  : consumer accepts the result
//   out_data   : converted word, registered, retained after handshake
//   out_id     : owner of out_data, registered, retained after handshake
//   out_parity : XOR-reduce of out_data (CC_PARITY_EN only)
//   busy       : high whenever the scheduler is not idle
module code_conv_sched #(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         req_mode,
  input  logic [N*W-1:0]       req_data,
  output logic [N-1:0]         grant,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_data,
  output logic [$clog2(N)-1:0] out_id,
`ifdef CC_PARITY_EN
  output logic                 out_parity,
`endif
  output logic                 busy
);

  localparam int IDW = $clog2(N);
  localparam int IW  = $clog2(W);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t         state, state_next;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] id_q;
  logic [W-1:0]   dat_q;
  logic           mode_q;
  logic [W-1:0]   res_q;
  logic [IW-1:0]  idx;
  logic [IW-1:0]  idx_up;

  logic           found;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] cand;
  logic [W-1:0]   sel_data;
  logic [W-1:0]   res_next;
  logic [W-1:0]   conv_result;

  // Round-robin search: walk ptr+1, ptr+2, ... with wrap at N-1. This also
  // works when N is not a power of two. The first set req bit wins.
  always_comb begin
    found  = 1'b0;
    win_id = '0;
    cand   = ptr;
    for (int k = 0; k < N; k++) begin
      cand = (cand == IDW'(N-1)) ? '0 : cand + 1'b1;
      if (!found && req[cand]) begin
        found  = 1'b1;
        win_id = cand;
      end
    end
  end

  assign sel_data = req_data[win_id*W +: W];

  // Serial Gray->binary step. Each bit is the XOR of the already-resolved
  // bit above it and the matching Gray bit. Binary->Gray is a single XOR.
  always_comb begin
    idx_up        = idx + 1'b1;
    res_next      = res_q;
    res_next[idx] = res_q[idx_up] ^ dat_q[idx];
    conv_result   = mode_q ? res_next : (dat_q ^ (dat_q >> 1));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic. Gray->binary leaves CONV on the edge that resolves
  // bit 0. Binary->Gray leaves CONV after a single edge.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (found) state_next = CONV;
      CONV:    if (!mode_q || idx == '0) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // Datapath. The grant pulse is registered together with the latch of the
  // winner's inputs, so it lines up exactly with the first CONV cycle. The
  // output registers load only when the FSM enters DONE. They keep their
  // value afterwards, and out_valid is what qualifies them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= IDW'(N-1);
      grant    <= '0;
      id_q     <= '0;
      dat_q    <= '0;
      mode_q   <= 1'b0;
      res_q    <= '0;
      idx      <= '0;
      out_data <= '0;
      out_id   <= '0;
`ifdef CC_PARITY_EN
      out_parity <= 1'b0;
`endif
    end else begin
      grant <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            grant[win_id] <= 1'b1;
            ptr           <= win_id;
            id_q          <= win_id;
            dat_q         <= sel_data;
            mode_q        <= req_mode[win_id];
            res_q         <= {sel_data[W-1], {(W-1){1'b0}}};
            idx           <= IW'(W-2);
          end
        end
        CONV: begin
          res_q <= res_next;
          if (mode_q && idx != '0) idx <= idx - 1'b1;
          if (state_next == DONE) begin
            out_data <= conv_result;
            out_id   <= id_q;
`ifdef CC_PARITY_EN
            out_parity <= ^conv_result;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
